// File: rtl/port_rx.sv
// Serial receiver for one router output port: reassembles LSB-first
// bits into bytes, buffers them in a FIFO and reports packet status.
module port_rx #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             dout_in,
  input  logic             frameo_n,
  input  logic             valido_n,
  input  logic             rd_en,
  input  logic             clr_err,
  output logic [7:0]       rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             pkt_done,
  output logic [7:0]       pkt_len,
  output logic             frag_err,
  output logic             ovf_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state_q, state_d;
  logic             armed_q, armed_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       byte_cnt_q, byte_cnt_d;
  logic             push_q, push_d;
  logic [7:0]       push_byte_q, push_byte_d;
  logic [CNT_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             pkt_done_q, pkt_done_d;
  logic [7:0]       pkt_len_q, pkt_len_d;
  logic             frag_q, frag_d;
  logic             ovf_q, ovf_d;

  logic [7:0] mem [FIFO_DEPTH];

  logic data_cyc;
  logic term;
  logic byte_done;
  logic pop;
  logic wr;

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q | frameo_n;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    byte_cnt_d  = byte_cnt_q;
    push_d      = 1'b0;
    push_byte_d = push_byte_q;
    pkt_done_d  = 1'b0;
    pkt_len_d   = pkt_len_q;

    // After reset, a frame already in flight must not be picked up midway
    data_cyc  = !valido_n &&
                ((state_q == RECV) || (!frameo_n && armed_q));
    term      = (state_q == RECV) && frameo_n;
    byte_done = data_cyc && (bit_cnt_q == 3'd7);

    if (state_q == IDLE && !frameo_n && armed_q)
      state_d = RECV;

    if (data_cyc) begin
      sh_d[bit_cnt_q] = dout_in;
      bit_cnt_d       = bit_cnt_q + 3'd1;
    end

    if (byte_done) begin
      push_d      = 1'b1;
      push_byte_d = sh_d;
      if (byte_cnt_q != 8'hFF)
        byte_cnt_d = byte_cnt_q + 8'd1;
    end

    frag_d = (frag_q & ~clr_err) | (term && bit_cnt_d != 3'd0);

    if (term) begin
      state_d    = IDLE;
      pkt_done_d = 1'b1;
      pkt_len_d  = byte_cnt_d;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 8'd0;
    end

    pop = rd_en && !empty_q;
    wr  = push_q && (!full_q || pop);

    ovf_d = (ovf_q & ~clr_err) | (push_q && full_q && !pop);

    wptr_d  = wptr_q + CNT_W'(wr);
    rptr_d  = rptr_q + CNT_W'(pop);
    count_d = wptr_d - rptr_d;
    full_d  = (count_d == CNT_W'(FIFO_DEPTH));
    empty_d = (count_d == '0);

    rd_data_d = pop ? mem[rptr_q[AW-1:0]] : rd_data_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      bit_cnt_q   <= 3'd0;
      sh_q        <= 8'h00;
      byte_cnt_q  <= 8'h00;
      push_q      <= 1'b0;
      push_byte_q <= 8'h00;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      rd_data_q   <= 8'h00;
      pkt_done_q  <= 1'b0;
      pkt_len_q   <= 8'h00;
      frag_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      byte_cnt_q  <= byte_cnt_d;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      rd_data_q   <= rd_data_d;
      pkt_done_q  <= pkt_done_d;
      pkt_len_q   <= pkt_len_d;
      frag_q      <= frag_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage is not reset; pointers alone define valid contents
  always_ff @(posedge clock) begin
    if (wr)
      mem[wptr_q[AW-1:0]] <= push_byte_q;
  end

  assign rd_data  = rd_data_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign pkt_done = pkt_done_q;
  assign pkt_len  = pkt_len_q;
  assign frag_err = frag_q;
  assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_port_rx.sv
// Directed testbench for port_rx with immediate-assertion checks.
module tb_port_rx;

  logic       clock;
  logic       reset_n;
  logic       dout_in;
  logic       frameo_n;
  logic       valido_n;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       pkt_done;
  logic [7:0] pkt_len;
  logic       frag_err;
  logic       ovf_err;

  int checks;
  int errors;
  int done_cnt;
  int done_ref;

  port_rx #(.FIFO_DEPTH(16), .CNT_W(5)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .dout_in  (dout_in),
    .frameo_n (frameo_n),
    .valido_n (valido_n),
    .rd_en    (rd_en),
    .clr_err  (clr_err),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .pkt_done (pkt_done),
    .pkt_len  (pkt_len),
    .frag_err (frag_err),
    .ovf_err  (ovf_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock)
    if (pkt_done === 1'b1)
      done_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fr,
                          input logic vl);
    dout_in  = b;
    frameo_n = fr;
    valido_n = vl;
    step();
    dout_in  = 1'b0;
    frameo_n = 1'b1;
    valido_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    for (int i = 0; i < 8; i++)
      send_bit(b[i], (last && i == 7), 1'b0);
  endtask

  task automatic pop(output logic [7:0] v);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    v = rd_data;
  endtask

  logic [7:0] v;

  initial begin
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    reset_n  = 1'b0;
    dout_in  = 1'b0;
    frameo_n = 1'b1;
    valido_n = 1'b1;
    rd_en    = 1'b0;
    clr_err  = 1'b0;
    step();
    step();
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 5'd0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_pkt_done", pkt_done, 1'b0);
    chk("rst_pkt_len", pkt_len, 8'h00);
    chk("rst_frag", frag_err, 1'b0);
    chk("rst_ovf", ovf_err, 1'b0);
    reset_n = 1'b1;
    step();
    step();

    // two-byte packet
    done_ref = done_cnt;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b1);
    chk("t1_done", pkt_done, 1'b1);
    chk("t1_len", pkt_len, 8'd2);
    step();
    chk("t1_done_off", pkt_done, 1'b0);
    chk("t1_count", count, 5'd2);
    chk("t1_frag", frag_err, 1'b0);
    pop(v);
    chk("t1_pop0", v, 8'hA5);
    pop(v);
    chk("t1_pop1", v, 8'h3C);
    chk("t1_empty", empty, 1'b1);
    chk("t1_done_once", done_cnt - done_ref, 1);

    // 0x81 with valid gaps after bits 2 and 5
    v = 8'h81;
    for (int i = 0; i < 8; i++) begin
      if (i == 3 || i == 6)
        send_bit(1'b1, 1'b0, 1'b1);
      send_bit(v[i], (i == 7), 1'b0);
    end
    chk("t2_len", pkt_len, 8'd1);
    chk("t2_frag", frag_err, 1'b0);
    step();
    chk("t2_count", count, 5'd1);
    pop(v);
    chk("t2_pop", v, 8'h81);

    // 11-bit packet: fragment error
    send_byte(8'h5A, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    chk("t3_len", pkt_len, 8'd1);
    chk("t3_frag", frag_err, 1'b1);
    chk("t3_count", count, 5'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t3_frag_clr", frag_err, 1'b0);
    pop(v);
    chk("t3_pop", v, 8'h5A);
    chk("t3_empty", empty, 1'b1);

    // 18 bytes, no reads: overflow
    for (int i = 0; i < 18; i++)
      send_byte(8'(i), (i == 17));
    step();
    step();
    chk("t4_count", count, 5'd16);
    chk("t4_full", full, 1'b1);
    chk("t4_ovf", ovf_err, 1'b1);
    chk("t4_len", pkt_len, 8'd18);
    for (int i = 0; i < 16; i++) begin
      pop(v);
      chk($sformatf("t4_pop%0d", i), v, 32'(i));
    end
    chk("t4_empty", empty, 1'b1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t4_ovf_clr", ovf_err, 1'b0);

    // full FIFO, pop during the push
    for (int i = 0; i < 16; i++)
      send_byte(8'h10 + 8'(i), (i == 15));
    step();
    step();
    chk("t5_full", full, 1'b1);
    send_byte(8'h77, 1'b1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t5_count", count, 5'd16);
    chk("t5_ovf", ovf_err, 1'b0);
    chk("t5_first", rd_data, 8'h10);
    for (int i = 1; i < 17; i++) begin
      pop(v);
      chk($sformatf("t5_pop%0d", i), v,
          (i == 16) ? 32'h77 : 32'(8'h10 + 8'(i)));
    end
    chk("t5_empty", empty, 1'b1);

    // reset mid-packet
    done_ref = done_cnt;
    send_byte(8'hF0, 1'b0);
    for (int i = 0; i < 4; i++)
      send_bit(1'b1, 1'b0, 1'b0);
    chk("t6_pre_count", count, 5'd1);
    frameo_n = 1'b0;
    valido_n = 1'b0;
    reset_n  = 1'b0;
    #2;
    chk("t6_count", count, 5'd0);
    chk("t6_empty", empty, 1'b1);
    chk("t6_pkt_len", pkt_len, 8'd0);
    chk("t6_rd_data", rd_data, 8'h00);
    chk("t6_pkt_done", pkt_done, 1'b0);
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++)
      send_bit(1'b1, 1'b0, 1'b0);
    step();
    step();
    chk("t6_ignored", count, 5'd0);
    chk("t6_no_done", done_cnt - done_ref, 0);
    send_byte(8'hC3, 1'b1);
    step();
    step();
    chk("t6_len", pkt_len, 8'd1);
    chk("t6_count1", count, 5'd1);
    chk("t6_frag", frag_err, 1'b0);
    pop(v);
    chk("t6_pop", v, 8'hC3);
    chk("t6_done_once", done_cnt - done_ref, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/port_rx.md
PORT_RX -- requirements
Module: port_rx

Interface
REQ-001 Parameter: FIFO_DEPTH, 16, byte FIFO entries (power of two, 4..64).
REQ-002 Parameter: CNT_W, 5, width of count output (log2(FIFO_DEPTH)+1).
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset, with ports named clock and reset_n.
REQ-004 clock  input  1  rising-edge clock shared with the router.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 dout_in  input  1  serial data from one router output port, LSB first.
REQ-007 frameo_n  input  1  active-low frame from the same output port.
REQ-008 valido_n  input  1  active-low bit-valid from the same output port.
REQ-009 rd_en  input  1  host pop request.
REQ-010 clr_err  input  1  clears sticky error flags.
REQ-011 rd_data  output  8  popped byte, registered.
REQ-012 empty  output  1  FIFO holds zero bytes.
REQ-013 full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-014 count  output  CNT_W  bytes currently stored.
REQ-015 pkt_done  output  1  one-cycle pulse at end of packet.
REQ-016 pkt_len  output  8  completed bytes of last packet, held until next pkt_done.
REQ-017 frag_err  output  1  sticky: a packet ended on a non-byte boundary.
REQ-018 ovf_err  output  1  sticky: a byte was dropped because the FIFO was full.

Function
REQ-019 The FSM SHALL have exactly two states, IDLE and RECV, and SHALL go IDLE->RECV on any cycle with frameo_n=0.
REQ-020 A cycle is a data cycle when valido_n=0 and either state=RECV or frameo_n=0; dout_in SHALL be shifted into bit position bit_cnt (0..7) on data cycles only.
REQ-021 Cycles with valido_n=1 inside a frame SHALL be ignored (no shift, no count change).
REQ-022 When bit position 7 is written, the assembled byte SHALL be pushed into the FIFO in the next cycle, bit_cnt SHALL wrap to 0, and the packet byte counter SHALL increment, saturating at 255.
REQ-023 In RECV, a cycle with frameo_n=1 SHALL terminate the packet; if valido_n=0 in that cycle its bit is the final bit and SHALL be absorbed first.
REQ-024 On termination the FSM SHALL return to IDLE; pkt_done SHALL pulse in the following cycle, with pkt_len updated in the same cycle.
REQ-025 If bit_cnt != 0 after the final bit, the partial byte SHALL be discarded, excluded from pkt_len, and frag_err SHALL set.
REQ-026 frameo_n=1 with valido_n=0 while in IDLE SHALL be ignored.
REQ-027 A push while full and not popping SHALL drop the byte, leave FIFO contents unchanged, and set ovf_err; the byte still counts toward pkt_len.
REQ-028 rd_en while empty SHALL be ignored; otherwise rd_data SHALL present the oldest byte one cycle after rd_en.
REQ-029 A simultaneous push and pop SHALL both succeed (including when full), leaving count unchanged.
REQ-030 full/empty/count SHALL be registered, wrap-safe pointer-derived, and consistent in every cycle.
REQ-031 On clr_err, frag_err and ovf_err SHALL clear, except that an error set in the same cycle SHALL win.

Reset
REQ-032 While reset_n=0: state=IDLE, bit_cnt=0, FIFO pointers=0, rd_data=8'h00, empty=1, full=0, count=0, pkt_done=0, pkt_len=0, frag_err=0, ovf_err=0.
REQ-033 Reset asserted mid-packet SHALL discard the partial packet with no pkt_done; after release, frameo_n must first be seen high before the next packet is accepted.

Verification
REQ-034 Two-byte packet 8'hA5, 8'h3C (bits LSB first, last bit with frameo_n=1) -> pkt_done once, pkt_len=2, two pops return A5 then 3C, empty=1.
REQ-035 Packet 8'h81 with valido_n=1 gaps after bits 2 and 5 -> byte 8'h81 stored, pkt_len=1, frag_err=0.
REQ-036 Packet of 11 valid bits -> pkt_len=1, one byte stored, frag_err=1; clr_err -> frag_err=0.
REQ-037 18 bytes with no reads (FIFO_DEPTH=16) -> count=16, full=1, ovf_err=1, pkt_len=18, pops return bytes 0..15.
REQ-038 Full FIFO, rd_en held during 8th-bit push -> count stays 16, no ovf_err, order preserved.
REQ-039 reset_n pulsed low after 12 bits of a packet -> all outputs at reset values, no pkt_done, next clean packet received correctly.
